// File: rtl/scie_fir_pkg.sv
// rtl/scie_fir_pkg.sv - SCIE instruction codes, FSM encoding and default sizes for the FIR sequencer
package scie_fir_pkg;

   localparam logic [31:0] INSN_LOAD = 32'd11;
   localparam logic [31:0] INSN_PUSH = 32'd43;
   localparam logic [31:0] INSN_READ = 32'd91;

   localparam int DEF_NTAPS  = 5;
   localparam int DEF_W      = 32;
   localparam int DEF_RD_LAT = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PUSH,
      ST_GAP,
      ST_READ,
      ST_WAIT
   } state_t;

endpackage

// File: rtl/scie_fir_sequencer.sv
// rtl/scie_fir_sequencer.sv - drives SCIEPipelined load/push/read instructions from cfg and sample streams
module scie_fir_sequencer
   import scie_fir_pkg::*;
#(
   parameter int NTAPS  = DEF_NTAPS,
   parameter int W      = DEF_W,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [$clog2(NTAPS):0] cfg_idx,
   input  logic signed [W-1:0]    cfg_real,
   input  logic signed [W-1:0]    cfg_imag,
   output logic                   cfg_err,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [W-1:0]    in_real,
   input  logic signed [W-1:0]    in_imag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [W-1:0]    out_real,
   output logic signed [W-1:0]    out_imag,
   output logic [NTAPS-1:0]       coef_mask,
   output logic                   busy,
   output logic                   scie_valid,
   output logic [31:0]            scie_insn,
   output logic signed [W-1:0]    scie_rs1_real,
   output logic signed [W-1:0]    scie_rs1_imag,
   output logic [31:0]            scie_rs2,
   input  logic signed [W-1:0]    scie_rd_real,
   input  logic signed [W-1:0]    scie_rd_imag
);

   localparam int IDXW = $clog2(NTAPS) + 1;
   localparam int CNTW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [IDXW-1:0] NTAPS_IDX = IDXW'(NTAPS);
   localparam logic [CNTW-1:0] CNT_INIT  = CNTW'(RD_LAT - 1);

   state_t              state_q;
   logic [CNTW-1:0]     cnt_q;
   logic [NTAPS-1:0]    coef_mask_q;
   logic                cfg_err_q;
   logic                scie_valid_q;
   logic [31:0]         scie_insn_q;
   logic signed [W-1:0] scie_rs1_real_q;
   logic signed [W-1:0] scie_rs1_imag_q;
   logic [31:0]         scie_rs2_q;
   logic                out_valid_q;
   logic signed [W-1:0] out_real_q;
   logic signed [W-1:0] out_imag_q;

   logic idle;
   logic out_free;
   logic in_fire;

   assign idle     = (state_q == ST_IDLE);
   assign out_free = !out_valid_q || out_ready;
   assign in_fire  = in_valid && in_ready;

   // A sample is only taken once every tap is known and its result has somewhere to land.
   assign cfg_ready = idle;
   assign in_ready  = idle && (&coef_mask_q) && !cfg_valid && out_free;
   assign busy      = !idle;

   assign cfg_err       = cfg_err_q;
   assign coef_mask     = coef_mask_q;
   assign out_valid     = out_valid_q;
   assign out_real      = out_real_q;
   assign out_imag      = out_imag_q;
   assign scie_valid    = scie_valid_q;
   assign scie_insn     = scie_insn_q;
   assign scie_rs1_real = scie_rs1_real_q;
   assign scie_rs1_imag = scie_rs1_imag_q;
   assign scie_rs2      = scie_rs2_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         coef_mask_q     <= '0;
         cfg_err_q       <= 1'b0;
         scie_valid_q    <= 1'b0;
         scie_insn_q     <= '0;
         scie_rs1_real_q <= '0;
         scie_rs1_imag_q <= '0;
         scie_rs2_q      <= '0;
         out_valid_q     <= 1'b0;
         out_real_q      <= '0;
         out_imag_q      <= '0;
      end else begin
         // Instruction bus is zero unless a state below issues a word for the next cycle.
         cfg_err_q       <= 1'b0;
         scie_valid_q    <= 1'b0;
         scie_insn_q     <= '0;
         scie_rs1_real_q <= '0;
         scie_rs1_imag_q <= '0;
         scie_rs2_q      <= '0;

         if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (cfg_valid) begin
                  if (cfg_idx < NTAPS_IDX) begin
                     state_q         <= ST_LOAD;
                     scie_valid_q    <= 1'b1;
                     scie_insn_q     <= INSN_LOAD;
                     scie_rs1_real_q <= cfg_real;
                     scie_rs1_imag_q <= cfg_imag;
                     scie_rs2_q      <= 32'(cfg_idx);
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end else if (in_fire) begin
                  state_q         <= ST_PUSH;
                  scie_valid_q    <= 1'b1;
                  scie_insn_q     <= INSN_PUSH;
                  scie_rs1_real_q <= in_real;
                  scie_rs1_imag_q <= in_imag;
               end
            end
            ST_LOAD: begin
               for (int i = 0; i < NTAPS; i++) begin
                  if (scie_rs2_q == 32'(i)) begin
                     coef_mask_q[i] <= 1'b1;
                  end
               end
               state_q <= ST_IDLE;
            end
            ST_PUSH: begin
               state_q <= ST_GAP;
            end
            ST_GAP: begin
               state_q      <= ST_READ;
               scie_valid_q <= 1'b1;
               scie_insn_q  <= INSN_READ;
            end
            ST_READ: begin
               state_q <= ST_WAIT;
               cnt_q   <= CNT_INIT;
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  out_real_q  <= scie_rd_real;
                  out_imag_q  <= scie_rd_imag;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNTW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
